// File: rtl/and_cosim_pkg.sv
// Shared definitions for the AND-gate co-simulation responder: link FSM encoding,
// default sizing and the response entry layout.
package and_cosim_pkg;

  localparam int DEF_WIDTH = 1;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic [1:0] {
    OFFLINE = 2'd0,
    ONLINE  = 2'd1,
    DRAIN   = 2'd2
  } link_state_e;

  // Queue entry at default sizing; the queue stores {y, tag} in this order.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] y;
    logic [DEF_TAG_W-1:0] tag;
  } rsp_entry_t;

endpackage

// File: rtl/and_rsp_fifo.sv
// In-order response queue: DEPTH entries, registered head, no same-cycle bypass.
// Head data reads as zero while empty so the response bus is quiet after reset.
module and_rsp_fifo #(
  parameter int DATA_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [DATA_W-1:0]          i_data,
  input  logic                       i_pop,
  output logic [DATA_W-1:0]          o_data,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_push;
  logic              w_pop;

  // Self-protecting: an overflowing push or an underflowing pop is ignored.
  assign w_push = i_push && (r_level != FULL_LVL);
  assign w_pop  = i_pop  && (r_level != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_data  = (r_level != '0) ? r_mem[r_rd_ptr] : '0;
  assign o_level = r_level;

endmodule

// File: rtl/and_gate_cosim_responder.sv
// Responder end of the AND-gate co-sim link: accepts tagged (a, b), queues a & b in order.
// Optional AND_COSIM_STATS_EN adds rsp_count / stall_count ports.
module and_gate_cosim_responder
  import and_cosim_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TAG_W = DEF_TAG_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   link_up,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [WIDTH-1:0]       req_a,
  input  logic [WIDTH-1:0]       req_b,
  input  logic [TAG_W-1:0]       req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_y,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic [$clog2(DEPTH):0] level,
  output logic                   link_busy,
`ifdef AND_COSIM_STATS_EN
  output logic [31:0]            rsp_count,
  output logic [15:0]            stall_count,
`endif
  output logic [1:0]             dbg_state
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] ONE_LVL  = LVL_W'(1);

  link_state_e             r_state;
  logic                    r_link_busy;
  logic                    w_push;
  logic                    w_pop;
  logic [WIDTH+TAG_W-1:0]  w_wr_data;
  logic [WIDTH+TAG_W-1:0]  w_rd_data;

  // Both channels: a transfer happens on a cycle where valid && ready at posedge clk.
  // req_ready and rsp_valid derive only from registered state, never from the peer's signal.
  assign req_ready = (r_state == ONLINE) && (level < FULL_LVL);
  assign rsp_valid = (level != '0);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready;
  assign w_wr_data = {req_a & req_b, req_tag};
  assign {rsp_y, rsp_tag} = w_rd_data;

  and_rsp_fifo #(
    .DATA_W (WIDTH + TAG_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_wr_data),
    .i_pop   (w_pop),
    .o_data  (w_rd_data),
    .o_level (level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= OFFLINE;
      r_link_busy <= 1'b0;
    end else begin
      case (r_state)
        OFFLINE: begin
          if (link_up) begin
            r_state     <= ONLINE;
            r_link_busy <= 1'b1;
          end
        end
        ONLINE: begin
          if (!link_up) begin
            if (level != '0) begin
              r_state <= DRAIN;
            end else begin
              r_state     <= OFFLINE;
              r_link_busy <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Link recovery wins over finishing the drain.
          if (link_up) begin
            r_state <= ONLINE;
          end else if ((level == '0) || ((level == ONE_LVL) && w_pop)) begin
            r_state     <= OFFLINE;
            r_link_busy <= 1'b0;
          end
        end
        default: begin
          r_state     <= OFFLINE;
          r_link_busy <= 1'b0;
        end
      endcase
    end
  end

  assign link_busy = r_link_busy;
  assign dbg_state = r_state;

`ifdef AND_COSIM_STATS_EN
  logic [31:0] r_rsp_count;
  logic [15:0] r_stall_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_count   <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop) r_rsp_count <= r_rsp_count + 32'd1;
      if (rsp_valid && !rsp_ready && (r_stall_count != 16'hFFFF))
        r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign rsp_count   = r_rsp_count;
  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_and_gate_cosim_responder.sv
// Directed bench for and_gate_cosim_responder with an in-order scoreboard of {y, tag}.
module tb_and_gate_cosim_responder;

  localparam int WIDTH = 1;
  localparam int TAG_W = 4;
  localparam int DEPTH = 4;
  localparam int EW    = WIDTH + TAG_W;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   link_up;
  logic                   req_valid;
  logic                   req_ready;
  logic [WIDTH-1:0]       req_a;
  logic [WIDTH-1:0]       req_b;
  logic [TAG_W-1:0]       req_tag;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_y;
  logic [TAG_W-1:0]       rsp_tag;
  logic [$clog2(DEPTH):0] level;
  logic                   link_busy;
  logic [1:0]             dbg_state;
`ifdef AND_COSIM_STATS_EN
  logic [31:0]            rsp_count;
  logic [15:0]            stall_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  and_gate_cosim_responder #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .link_up     (link_up),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_tag     (req_tag),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .rsp_tag     (rsp_tag),
    .level       (level),
    .link_busy   (link_busy),
`ifdef AND_COSIM_STATS_EN
    .rsp_count   (rsp_count),
    .stall_count (stall_count),
`endif
    .dbg_state   (dbg_state)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver + scoreboard: record handshakes of the coming edge, then advance one cycle
  task automatic step();
    logic [EW-1:0] e;
    #1;
    if (req_valid && req_ready) exp_q.push_back({req_a & req_b, req_tag});
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("sb_rsp_without_req", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sb_rsp", {rsp_y, rsp_tag}, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic v, input logic a, input logic b, input logic [TAG_W-1:0] t);
    req_valid = v;
    req_a     = a;
    req_b     = b;
    req_tag   = t;
  endtask

  task automatic drain_all();
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) step();
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    link_up   = 1'b0;
    rsp_ready = 1'b0;
    set_req(1'b0, 1'b0, 1'b0, '0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_y", rsp_y, 0);
    check_eq("rst_rsp_tag", rsp_tag, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_link_busy", link_busy, 0);
    check_eq("rst_state", dbg_state, 0);
    rst_n = 1'b1;
    tick();
    check_eq("offline_hold", dbg_state, 0);
    link_up = 1'b1;
    tick();
    check_eq("online_state", dbg_state, 1);
    check_eq("online_ready", req_ready, 1);
    check_eq("online_busy", link_busy, 1);

    // basic transfer, 1-cycle latency
    set_req(1'b1, 1'b1, 1'b1, 4'd3);
    step();
    set_req(1'b0, 1'b0, 1'b0, '0);
    check_eq("basic1_valid", rsp_valid, 1);
    check_eq("basic1_y", rsp_y, 1);
    check_eq("basic1_tag", rsp_tag, 3);
    check_eq("basic1_level", level, 1);
    rsp_ready = 1'b1;
    step();
    check_eq("basic1_empty", rsp_valid, 0);
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 1'b0, 4'd4);
    step();
    set_req(1'b0, 1'b0, 1'b0, '0);
    check_eq("basic2_valid", rsp_valid, 1);
    check_eq("basic2_y", rsp_y, 0);
    check_eq("basic2_tag", rsp_tag, 4);
    rsp_ready = 1'b1;
    step();

    // backpressure: fill to DEPTH, then release in tag order
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'(i), 1'b1, 4'(i));
      check_eq("bp_ready_fill", req_ready, 1);
      step();
    end
    set_req(1'b0, 1'b0, 1'b0, '0);
    check_eq("bp_full_level", level, 4);
    check_eq("bp_full_ready", req_ready, 0);
    check_eq("bp_head_tag", rsp_tag, 0);
    rsp_ready = 1'b1;
    step();
    check_eq("bp_ready_after_pop", req_ready, 1);
    repeat (3) step();
    check_eq("bp_drained", level, 0);

    // full with simultaneous pop: no pass-through, accept lands a cycle later
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_req(1'b1, 1'b1, 1'(i), 4'(8 + i));
      step();
    end
    rsp_ready = 1'b1;
    set_req(1'b1, 1'b1, 1'b1, 4'd12);
    check_eq("full_no_accept", req_ready, 0);
    step();
    check_eq("full_pop_level", level, 3);
    check_eq("full_ready_back", req_ready, 1);
    step();
    check_eq("push_pop_level", level, 3);
    set_req(1'b0, 1'b0, 1'b0, '0);
    drain_all();
    check_eq("full_drained", level, 0);

    // drain on link loss
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 4'd5);
    step();
    set_req(1'b1, 1'b0, 1'b1, 4'd6);
    step();
    set_req(1'b1, 1'b1, 1'b1, 4'd7);
    step();
    set_req(1'b0, 1'b0, 1'b0, '0);
    link_up = 1'b0;
    step();
    set_req(1'b1, 1'b1, 1'b1, 4'd9);
    check_eq("drain_state", dbg_state, 2);
    check_eq("drain_ready", req_ready, 0);
    check_eq("drain_busy", link_busy, 1);
    check_eq("drain_level", level, 3);
    rsp_ready = 1'b1;
    step();
    step();
    check_eq("drain_mid_busy", link_busy, 1);
    check_eq("drain_mid_level", level, 1);
    step();
    check_eq("drain_offline", dbg_state, 0);
    check_eq("drain_idle", link_busy, 0);
    check_eq("drain_empty", level, 0);
    check_eq("drain_sb_empty", exp_q.size(), 0);
    set_req(1'b0, 1'b0, 1'b0, '0);

    // asynchronous reset mid-traffic
    link_up = 1'b1;
    step();
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 4'd1);
    step();
    set_req(1'b1, 1'b1, 1'b1, 4'd2);
    step();
    set_req(1'b0, 1'b0, 1'b0, '0);
    check_eq("arst_pre_level", level, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_rsp_valid", rsp_valid, 0);
    check_eq("arst_level", level, 0);
    check_eq("arst_req_ready", req_ready, 0);
    check_eq("arst_busy", link_busy, 0);
    check_eq("arst_tag", rsp_tag, 0);
    check_eq("arst_state", dbg_state, 0);
`ifdef AND_COSIM_STATS_EN
    check_eq("arst_rsp_count", rsp_count, 0);
    check_eq("arst_stall_count", stall_count, 0);
`endif
    exp_q.delete();
    tick();
    rst_n     = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("no_stale_rsp", rsp_valid, 0);
    end

`ifdef AND_COSIM_STATS_EN
    // 5 transfers, stalls 2+0+3+1+1 = 7
    begin
      int st[5];
      st = '{2, 0, 3, 1, 1};
      for (int t = 0; t < 5; t++) begin
        rsp_ready = 1'b0;
        set_req(1'b1, 1'b1, 1'b1, 4'(t));
        step();
        set_req(1'b0, 1'b0, 1'b0, '0);
        repeat (st[t]) step();
        rsp_ready = 1'b1;
        step();
      end
      check_eq("stats_rsp_count", rsp_count, 5);
      check_eq("stats_stall_count", stall_count, 7);
    end
`endif

    // still alive after reset
    rsp_ready = 1'b0;
    set_req(1'b1, 1'b1, 1'b1, 4'd15);
    step();
    set_req(1'b0, 1'b0, 1'b0, '0);
    check_eq("post_rst_tag", rsp_tag, 15);
    check_eq("post_rst_y", rsp_y, 1);
    drain_all();
    check_eq("final_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
